cmp_bitmap_feeder: RTL

- Upstream feeder for the compare ALU.
- Loads one 64-row x 24-column glyph bitmap from word memory into a local register array, with one 24-bit word per row.
- Then serves the ALU three independent streams: columns (64-bit, left to right), top rows (descending from row 0) and bottom rows (ascending from row 63).
- Waits for the ALU to finish, captures its 16-bit result and reports done to the controller.

---
 rtl/cmp_bitmap_feeder.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/cmp_bitmap_feeder.sv
// Glyph bitmap feeder for the compare ALU: loads a ROWS x COLS bitmap from word
// memory, then serves column, top-row and bottom-row streams paced by the ALU.
module cmp_bitmap_feeder #(
  parameter int ROWS = 64,
  parameter int COLS = 24,
  parameter int AW   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      base_addr,
  output logic             busy,
  output logic             done,
  output logic [15:0]      result,
  output logic             mem_rd,
  output logic [15:0]      mem_addr,
  input  logic [COLS-1:0]  mem_data,
  input  logic             mem_valid,
  output logic             alu_start,
  output logic [ROWS-1:0]  bitcolumn,
  output logic [COLS-1:0]  bitrowtop,
  output logic [COLS-1:0]  bitrowbot,
  output logic             nextcolumnready,
  output logic             nextrowtopready,
  output logic             nextrowbotready,
  input  logic             nextcolumn,
  input  logic             nextrowtop,
  input  logic             nextrowbot,
  output logic             lastcolumn,
  input  logic             alu_done,
  input  logic [15:0]      alu_result
);

  localparam int CW = $clog2(COLS);
  localparam logic [AW-1:0] FIRST_ROW = '0;
  localparam logic [AW-1:0] LAST_ROW  = AW'(ROWS - 1);
  localparam logic [AW-1:0] TOP_LAST  = AW'(ROWS / 2 - 1);
  localparam logic [AW-1:0] BOT_LAST  = AW'(ROWS / 2);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;

  logic [COLS-1:0] bitmap [ROWS];
  logic [15:0]     base_q;
  logic [AW-1:0]   row_idx;
  logic [CW-1:0]   col_idx;
  logic [AW-1:0]   top_idx;
  logic [AW-1:0]   bot_idx;
  logic [2:0]      req_q;
  logic [2:0]      req_rise;
  logic            load_we;
  logic            col_end, top_end, bot_end;
  logic            col_adv, top_adv, bot_adv;
  logic [CW-1:0]   col_sel;
  logic [ROWS-1:0] col_vec;

  // Requests are levels; only a 0->1 transition asks for the next item.
  assign req_rise = {nextrowbot, nextrowtop, nextcolumn} & ~req_q;

  // A read strobe and its data never share a cycle, so valid during mem_rd is stray.
  assign load_we = (state == S_LOAD) && mem_valid && !mem_rd;

  assign col_end = (col_idx == LAST_COL);
  assign top_end = (top_idx == TOP_LAST);
  assign bot_end = (bot_idx == BOT_LAST);

  assign col_adv = (state == S_STREAM) && req_rise[0] && !col_end;
  assign top_adv = (state == S_STREAM) && req_rise[1] && !top_end;
  assign bot_adv = (state == S_STREAM) && req_rise[2] && !bot_end;

  // Column about to be presented: 0 when leaving KICK, otherwise the successor.
  always_comb begin
    col_sel = '0;
    if (state == S_STREAM && !col_end) begin
      col_sel = col_idx + 1'b1;
    end
    col_vec = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      col_vec[AW'(r)] = bitmap[AW'(r)][LAST_COL - col_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (load_we) begin
      bitmap[row_idx] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      result          <= '0;
      mem_rd          <= 1'b0;
      mem_addr        <= '0;
      alu_start       <= 1'b0;
      bitcolumn       <= '0;
      bitrowtop       <= '0;
      bitrowbot       <= '0;
      nextcolumnready <= 1'b0;
      nextrowtopready <= 1'b0;
      nextrowbotready <= 1'b0;
      lastcolumn      <= 1'b0;
      base_q          <= '0;
      row_idx         <= '0;
      col_idx         <= '0;
      top_idx         <= '0;
      bot_idx         <= '0;
      req_q           <= '0;
    end else begin
      req_q           <= {nextrowbot, nextrowtop, nextcolumn};
      mem_rd          <= 1'b0;
      alu_start       <= 1'b0;
      done            <= 1'b0;
      nextcolumnready <= 1'b0;
      nextrowtopready <= 1'b0;
      nextrowbotready <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_LOAD;
            busy       <= 1'b1;
            base_q     <= base_addr;
            row_idx    <= '0;
            mem_rd     <= 1'b1;
            mem_addr   <= base_addr;
            lastcolumn <= 1'b0;
          end
        end

        S_LOAD: begin
          if (load_we) begin
            if (row_idx == LAST_ROW) begin
              state     <= S_KICK;
              alu_start <= 1'b1;
            end else begin
              row_idx  <= row_idx + 1'b1;
              mem_rd   <= 1'b1;
              mem_addr <= base_q + {{(16 - AW){1'b0}}, row_idx} + 16'd1;
            end
          end
        end

        S_KICK: begin
          state           <= S_STREAM;
          col_idx         <= '0;
          top_idx         <= FIRST_ROW;
          bot_idx         <= LAST_ROW;
          bitcolumn       <= col_vec;
          bitrowtop       <= bitmap[FIRST_ROW];
          bitrowbot       <= bitmap[LAST_ROW];
          nextcolumnready <= 1'b1;
          nextrowtopready <= 1'b1;
          nextrowbotready <= 1'b1;
        end

        S_STREAM: begin
          if (col_end && top_end && bot_end) begin
            state <= S_DRAIN;
          end
          if (col_adv) begin
            col_idx         <= col_idx + 1'b1;
            bitcolumn       <= col_vec;
            nextcolumnready <= 1'b1;
            if (col_idx + 1'b1 == LAST_COL) begin
              lastcolumn <= 1'b1;
            end
          end
          if (top_adv) begin
            top_idx         <= top_idx + 1'b1;
            bitrowtop       <= bitmap[top_idx + 1'b1];
            nextrowtopready <= 1'b1;
          end
          if (bot_adv) begin
            bot_idx         <= bot_idx - 1'b1;
            bitrowbot       <= bitmap[bot_idx - 1'b1];
            nextrowbotready <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (alu_done) begin
            state      <= S_DONE;
            result     <= alu_result;
            done       <= 1'b1;
            busy       <= 1'b0;
            lastcolumn <= 1'b0;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
